// File: rtl/spk_pkg.sv
// Shared constants and types for the speaker drive path (clock bit taps, frame width, sample type).
// The optional SPK_MUTE_EN macro is consumed by speaker_drive, not by this package.
package spk_pkg;

  localparam int unsigned FCNT_W       = 9;   // 512-cycle frame counter
  localparam int unsigned MCLK_BIT     = 1;   // clk/4
  localparam int unsigned SCK_BIT      = 3;   // clk/16
  localparam int unsigned LRCK_BIT     = 8;   // clk/512
  localparam int unsigned SLOT_W       = LRCK_BIT - SCK_BIT - 1;  // bit slots per channel (log2)
  localparam int unsigned SPK_SAMPLE_W = 16;

  typedef logic [SPK_SAMPLE_W-1:0] sample_t;

  // Last cycle of a frame: the only cycle in which a new sample is captured.
  function automatic logic frame_last(input logic [FCNT_W-1:0] fcnt);
    return &fcnt;
  endfunction

endpackage

// File: rtl/i2s_serializer.sv
// I2S-style serializer: frame counter, DAC clocks, per-frame sample register and MSB-first data.
// Both channels of a frame carry the same captured sample.
module i2s_serializer
  import spk_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SPK_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_mclk,
  output logic                o_sck,
  output logic                o_lrck,
  output logic                o_sdin
);

  localparam int unsigned IDX_W = $clog2(SAMPLE_W);

  logic [FCNT_W-1:0]   r_fcnt;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_mclk;
  logic                r_sck;
  logic                r_lrck;
  logic                r_sdin;

  logic [FCNT_W-1:0]   w_fcnt_nxt;
  logic                w_load;
  logic [SAMPLE_W-1:0] w_sample_nxt;
  logic [SLOT_W-1:0]   w_slot;
  logic [IDX_W-1:0]    w_bit_idx;
  logic                w_bit_start;

  assign w_fcnt_nxt   = r_fcnt + FCNT_W'(1);
  assign w_load       = frame_last(r_fcnt);
  assign w_sample_nxt = w_load ? i_sample : r_sample;
  assign w_slot       = w_fcnt_nxt[LRCK_BIT-1:SCK_BIT+1];
  assign w_bit_idx    = IDX_W'(SAMPLE_W - 1) - IDX_W'(w_slot);
  assign w_bit_start  = (w_fcnt_nxt[SCK_BIT:0] == '0);

  // Clock outputs track the next counter value so they equal the counter bits cycle-for-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt   <= '0;
      r_sample <= '0;
      r_mclk   <= 1'b0;
      r_sck    <= 1'b0;
      r_lrck   <= 1'b0;
      r_sdin   <= 1'b0;
    end else begin
      r_fcnt   <= w_fcnt_nxt;
      r_sample <= w_sample_nxt;
      r_mclk   <= w_fcnt_nxt[MCLK_BIT];
      r_sck    <= w_fcnt_nxt[SCK_BIT];
      r_lrck   <= w_fcnt_nxt[LRCK_BIT];
      if (w_bit_start) begin
        r_sdin <= w_sample_nxt[w_bit_idx];
      end
    end
  end

  assign o_mclk = r_mclk;
  assign o_sck  = r_sck;
  assign o_lrck = r_lrck;
  assign o_sdin = r_sdin;

endmodule

// File: rtl/speaker_drive.sv
// Square-wave tone generator feeding an I2S DAC serializer.
// Optional macro SPK_MUTE_EN adds a mute input that zeroes the captured sample.
module speaker_drive
  import spk_pkg::*;
#(
  parameter int unsigned DIV_W    = 22,
  parameter int unsigned SAMPLE_W = SPK_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] amplitude,
  input  logic [DIV_W-1:0]    note_div,
`ifdef SPK_MUTE_EN
  input  logic                mute,
`endif
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  output logic                audio_sdin
);

  logic [DIV_W-1:0]    r_tone_cnt;
  logic                r_phase;

  logic                w_div_zero;
  logic [DIV_W-1:0]    w_div_last;
  logic                w_wrap;
  logic [SAMPLE_W-1:0] w_sample;

  assign w_div_zero = (note_div == '0);
  assign w_div_last = note_div - DIV_W'(1);
  // >= rather than == so a shrinking divider toggles at once instead of wrapping.
  assign w_wrap     = (r_tone_cnt >= w_div_last);

  // Half-period counter; toggles the tone phase each time it reaches the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone_cnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_div_zero) begin
      r_tone_cnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_wrap) begin
      r_tone_cnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_tone_cnt <= r_tone_cnt + DIV_W'(1);
    end
  end

  // Signed square-wave sample presented to the serializer for frame-boundary capture.
  always_comb begin
    w_sample = '0;
    if (!w_div_zero) begin
      w_sample = r_phase ? amplitude : (~amplitude + SAMPLE_W'(1));
    end
`ifdef SPK_MUTE_EN
    if (mute) begin
      w_sample = '0;
    end
`endif
  end

  i2s_serializer #(
    .SAMPLE_W (SAMPLE_W)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (w_sample),
    .o_mclk   (audio_mclk),
    .o_sck    (audio_sck),
    .o_lrck   (audio_lrck),
    .o_sdin   (audio_sdin)
  );

endmodule

// File: tb/tb_speaker_drive.sv
// Directed bench for speaker_drive: clock taps, frame contents, divider changes, reset, optional mute.
module tb_speaker_drive;

  logic        clk;
  logic        rst_n;
  logic [15:0] amplitude;
  logic [21:0] note_div;
`ifdef SPK_MUTE_EN
  logic        mute;
  logic        pend_mute;
`endif
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;

  int unsigned p_cnt;      // posedges since reset release == expected fcnt modulo 512
  int          vectors;
  int          errors;
  logic [15:0] pend_amp;
  logic [21:0] pend_div;

  speaker_drive #(
    .DIV_W    (22),
    .SAMPLE_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .amplitude  (amplitude),
    .note_div   (note_div),
`ifdef SPK_MUTE_EN
    .mute       (mute),
`endif
    .audio_mclk (audio_mclk),
    .audio_sck  (audio_sck),
    .audio_lrck (audio_lrck),
    .audio_sdin (audio_sdin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_cnt <= 0;
    else        p_cnt <= p_cnt + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, p_cnt=%0d", p_cnt);
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [15:0] amp, input logic [21:0] div);
    rst_n     = 1'b0;
    amplitude = amp;
    note_div  = div;
`ifdef SPK_MUTE_EN
    mute      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance to the negedge that follows posedge number 'target'.
  task automatic wait_p(input int unsigned target);
    while (p_cnt < target) @(negedge clk);
  endtask

  // Collect frame k from sdin at mid-bit; at offset chg_at apply the pending input values.
  task automatic capture_frame(input int unsigned k, input int chg_at,
                               output logic [15:0] l, output logic [15:0] r);
    logic [8:0] f;
    wait_p(512 * k);
    l = '0;
    r = '0;
    for (int i = 0; i < 512; i++) begin
      if (i == chg_at) begin
        amplitude = pend_amp;
        note_div  = pend_div;
`ifdef SPK_MUTE_EN
        mute      = pend_mute;
`endif
      end
      f = p_cnt[8:0];
      if (f[3:0] == 4'd8) begin
        if (f[8]) r[15 - f[7:4]] = audio_sdin;
        else      l[15 - f[7:4]] = audio_sdin;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    amplitude = 16'h39FF;
    note_div  = 22'd1000;
`ifdef SPK_MUTE_EN
    mute      = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (audio_mclk !== 1'b0) begin errors++; $display("FAIL reset_mclk: got %b want 0", audio_mclk); end
    vectors++; if (audio_sck  !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", audio_sck); end
    vectors++; if (audio_lrck !== 1'b0) begin errors++; $display("FAIL reset_lrck: got %b want 0", audio_lrck); end
    vectors++; if (audio_sdin !== 1'b0) begin errors++; $display("FAIL reset_sdin: got %b want 0", audio_sdin); end
    vectors++; if (p_cnt != 0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", p_cnt); end
  endtask

  task automatic test_silence();
    int bad_mclk, bad_sck, bad_lrck, bad_sdin;
    logic [8:0] f;
    bad_mclk = 0; bad_sck = 0; bad_lrck = 0; bad_sdin = 0;
    do_reset(16'h39FF, 22'd0);
    for (int i = 0; i < 1100; i++) begin
      f = p_cnt[8:0];
      if (audio_mclk !== f[1]) bad_mclk++;
      if (audio_sck  !== f[3]) bad_sck++;
      if (audio_lrck !== f[8]) bad_lrck++;
      if (audio_sdin !== 1'b0) bad_sdin++;
      @(negedge clk);
    end
    vectors++; if (bad_mclk != 0) begin errors++; $display("FAIL silence_mclk_period4: %0d bad cycles, want 0", bad_mclk); end
    vectors++; if (bad_sck  != 0) begin errors++; $display("FAIL silence_sck_period16: %0d bad cycles, want 0", bad_sck); end
    vectors++; if (bad_lrck != 0) begin errors++; $display("FAIL silence_lrck_period512: %0d bad cycles, want 0", bad_lrck); end
    vectors++; if (bad_sdin != 0) begin errors++; $display("FAIL silence_sdin_zero: %0d bad cycles, want 0", bad_sdin); end
  endtask

  task automatic test_tone();
    logic [15:0] l, r;
    int unsigned fr [10];
    logic [15:0] ex [10];
    do_reset(16'h39FF, 22'd50000);
    pend_amp = 16'h39FF; pend_div = 22'd50000;
`ifdef SPK_MUTE_EN
    pend_mute = 1'b0;
`endif
    // Frame 0 precedes the first load; frame 1 carries the negative half.
    capture_frame(0, 512, l, r);
    vectors++; if (l !== 16'h0000) begin errors++; $display("FAIL frame0_left: got %h want 0000", l); end
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL frame0_right: got %h want 0000", r); end
    capture_frame(1, 512, l, r);
    vectors++; if (l !== 16'hC601) begin errors++; $display("FAIL frame1_left: got %h want c601", l); end
    vectors++; if (r !== 16'hC601) begin errors++; $display("FAIL frame1_right: got %h want c601", r); end
    // Amplitude change at fcnt=100 must not disturb the frame in flight.
    pend_amp = 16'h5FFF;
    capture_frame(2, 100, l, r);
    vectors++; if (l !== 16'hC601) begin errors++; $display("FAIL amp_change_cur_left: got %h want c601", l); end
    vectors++; if (r !== 16'hC601) begin errors++; $display("FAIL amp_change_cur_right: got %h want c601", r); end
    capture_frame(3, 512, l, r);
    vectors++; if (l !== 16'hA001) begin errors++; $display("FAIL amp_change_next_left: got %h want a001", l); end
    vectors++; if (r !== 16'hA001) begin errors++; $display("FAIL amp_change_next_right: got %h want a001", r); end
    // Phase flips at posedge 50000: frame 97 loads before it, frame 98 after.
    capture_frame(97, 512, l, r);
    vectors++; if (l !== 16'hA001 || r !== 16'hA001) begin errors++; $display("FAIL frame97: got %h/%h want a001/a001", l, r); end
    capture_frame(98, 512, l, r);
    vectors++; if (l !== 16'h5FFF || r !== 16'h5FFF) begin errors++; $display("FAIL frame98_toggle50000: got %h/%h want 5fff/5fff", l, r); end
    capture_frame(135, 512, l, r);
    vectors++; if (l !== 16'h5FFF || r !== 16'h5FFF) begin errors++; $display("FAIL frame135: got %h/%h want 5fff/5fff", l, r); end
    // note_div drops to 1000 right after posedge 70000 (tone_cnt=20000), mid-frame 136.
    pend_div = 22'd1000;
    capture_frame(136, 70000 - 136 * 512, l, r);
    vectors++; if (l !== 16'h5FFF || r !== 16'h5FFF) begin errors++; $display("FAIL div_change_cur: got %h/%h want 5fff/5fff", l, r); end
    // Toggle at posedge 70001, then every 1000 clk.
    fr[0] = 137; ex[0] = 16'hA001;
    fr[1] = 139; ex[1] = 16'h5FFF;
    fr[2] = 141; ex[2] = 16'hA001;
    fr[3] = 143; ex[3] = 16'h5FFF;
    for (int i = 0; i < 4; i++) begin
      capture_frame(fr[i], 512, l, r);
      vectors++;
      if (l !== ex[i] || r !== ex[i]) begin
        errors++;
        $display("FAIL div_drop_frame%0d: got %h/%h want %h/%h", fr[i], l, r, ex[i], ex[i]);
      end
    end
  endtask

  task automatic test_zero_amp();
    logic [15:0] l, r;
    do_reset(16'h0000, 22'd1000);
    pend_amp = 16'h0000; pend_div = 22'd1000;
`ifdef SPK_MUTE_EN
    pend_mute = 1'b0;
`endif
    capture_frame(1, 512, l, r);  // negative phase: -0
    vectors++; if (l !== 16'h0000) begin errors++; $display("FAIL zero_neg_left: got %h want 0000", l); end
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL zero_neg_right: got %h want 0000", r); end
    capture_frame(2, 512, l, r);  // positive phase
    vectors++; if (l !== 16'h0000) begin errors++; $display("FAIL zero_pos_left: got %h want 0000", l); end
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL zero_pos_right: got %h want 0000", r); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] l, r;
    do_reset(16'h39FF, 22'd50000);
    pend_amp = 16'h39FF; pend_div = 22'd50000;
`ifdef SPK_MUTE_EN
    pend_mute = 1'b0;
`endif
    // fcnt=270 in frame 2: mclk, sck, lrck high, sdin = bit15 of c601.
    wait_p(1024 + 270);
    vectors++; if (audio_mclk !== 1'b1) begin errors++; $display("FAIL pre_rst_mclk: got %b want 1", audio_mclk); end
    vectors++; if (audio_sck  !== 1'b1) begin errors++; $display("FAIL pre_rst_sck: got %b want 1", audio_sck); end
    vectors++; if (audio_lrck !== 1'b1) begin errors++; $display("FAIL pre_rst_lrck: got %b want 1", audio_lrck); end
    vectors++; if (audio_sdin !== 1'b1) begin errors++; $display("FAIL pre_rst_sdin: got %b want 1", audio_sdin); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (audio_mclk !== 1'b0) begin errors++; $display("FAIL mid_rst_mclk: got %b want 0", audio_mclk); end
    vectors++; if (audio_sck  !== 1'b0) begin errors++; $display("FAIL mid_rst_sck: got %b want 0", audio_sck); end
    vectors++; if (audio_lrck !== 1'b0) begin errors++; $display("FAIL mid_rst_lrck: got %b want 0", audio_lrck); end
    vectors++; if (audio_sdin !== 1'b0) begin errors++; $display("FAIL mid_rst_sdin: got %b want 0", audio_sdin); end
    do_reset(16'h39FF, 22'd50000);
    capture_frame(0, 512, l, r);
    vectors++; if (l !== 16'h0000 || r !== 16'h0000) begin errors++; $display("FAIL post_rst_frame0: got %h/%h want 0000/0000", l, r); end
    capture_frame(1, 512, l, r);
    vectors++; if (l !== 16'hC601 || r !== 16'hC601) begin errors++; $display("FAIL post_rst_frame1: got %h/%h want c601/c601", l, r); end
  endtask

`ifdef SPK_MUTE_EN
  task automatic test_mute();
    logic [15:0] l, r;
    do_reset(16'h39FF, 22'd1000);
    pend_amp = 16'h39FF; pend_div = 22'd1000; pend_mute = 1'b0;
    wait_p(512 + 300);
    mute = 1'b1;
    // Frame 2 would be +39ff; mute released at fcnt=50 of that frame.
    capture_frame(2, 50, l, r);
    vectors++; if (l !== 16'h0000 || r !== 16'h0000) begin errors++; $display("FAIL mute_frame: got %h/%h want 0000/0000", l, r); end
    capture_frame(3, 512, l, r);
    vectors++; if (l !== 16'h39FF || r !== 16'h39FF) begin errors++; $display("FAIL unmute_frame: got %h/%h want 39ff/39ff", l, r); end
    capture_frame(4, 512, l, r);
    vectors++; if (l !== 16'hC601 || r !== 16'hC601) begin errors++; $display("FAIL mute_tone_running: got %h/%h want c601/c601", l, r); end
  endtask
`endif

  initial begin
    vectors  = 0;
    errors   = 0;
    pend_amp = 16'h0000;
    pend_div = 22'd0;
`ifdef SPK_MUTE_EN
    pend_mute = 1'b0;
`endif
    test_reset();
    test_silence();
    test_tone();
    test_zero_amp();
    test_mid_reset();
`ifdef SPK_MUTE_EN
    test_mute();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/speaker_drive.md
SPEAKER_DRIVE -- requirements
Module: speaker_drive

Interface
REQ-001 Parameter DIV_W, default 22, width of note_div and of the tone counter.
REQ-002 Parameter SAMPLE_W, default 16, width of amplitude and of the serialized sample.
REQ-003 clk  input  1  system clock, 100 MHz, single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 amplitude  input  SAMPLE_W  unsigned volume magnitude from the volume-setting stage.
REQ-006 note_div  input  DIV_W  tone half-period in clk cycles; 0 = silence.
REQ-007 audio_mclk  output  1  DAC master clock, clk/4.
REQ-008 audio_sck  output  1  DAC serial bit clock, clk/16.
REQ-009 audio_lrck  output  1  DAC word select, clk/512; 0 = left, 1 = right.
REQ-010 audio_sdin  output  1  DAC serial data, MSB first, two's complement.

Function
REQ-011 A free-running 9-bit frame counter fcnt SHALL increment every clk and wrap 511->0.
REQ-012 audio_mclk SHALL equal fcnt[1], audio_sck SHALL equal fcnt[3], and audio_lrck SHALL equal fcnt[8], all driven from registers.
REQ-013 The tone counter SHALL increment every clk; when tone_cnt >= note_div-1 it SHALL clear to 0 and toggle phase in the same cycle.
REQ-014 A decrease of note_div below the current tone_cnt SHALL produce a toggle on the next clk, with no wrap through 2^DIV_W.
REQ-015 While note_div == 0, tone_cnt and phase SHALL be held at 0 and the computed sample SHALL be 0.
REQ-016 The computed sample SHALL be +amplitude when phase=1 and the two's-complement negation of amplitude, truncated to SAMPLE_W, when phase=0.
REQ-017 The sample register SHALL load the computed sample only in the clk where fcnt == 511; it is constant for the whole 512-cycle frame.
REQ-018 Both channels SHALL carry the same sample register value within a frame.
REQ-019 Within each channel half-frame, audio_sdin SHALL present sample bit [15 - fcnt[7:4]], updating only when fcnt[3:0] == 0 (sck falling edge).
REQ-020 Latency from a change on amplitude or phase to its first MSB on audio_sdin SHALL be at most 513 clk.
REQ-021 Mid-frame changes on amplitude or note_div SHALL NOT alter bits of the frame in progress.

Reset
REQ-022 While rst_n = 0, fcnt, tone_cnt, phase, the sample register, and all five outputs SHALL be 0.
REQ-023 After rst_n deasserts, the first sample register load SHALL occur at fcnt == 511, 512 clk later.
REQ-024 Assertion of rst_n mid-frame SHALL force all state to 0 immediately, with no frame completion.

Configuration
REQ-025 Macro SPK_MUTE_EN SHALL add input port mute (1 bit).
REQ-026 With SPK_MUTE_EN defined, mute = 1 sampled at fcnt == 511 SHALL load 0 into the sample register; the tone counter keeps running.
REQ-027 Without SPK_MUTE_EN, the port SHALL be absent and behaviour SHALL be as in REQ-017.

Structure
REQ-028 Package spk_pkg SHALL hold FCNT_W=9, the MCLK/SCK/LRCK bit-index constants, and the sample_t typedef (SAMPLE_W bits).
REQ-029 Serialization (fcnt, clock outputs, sample register, sdin) SHALL be sub-module i2s_serializer; tone generation SHALL stay in speaker_drive.

Verification
REQ-030 Reset release, note_div=0 -> mclk period 4, sck period 16, lrck period 512 clk; sdin constant 0.
REQ-031 note_div=50000, amplitude=16'h39FF -> phase toggles every 50000 clk; frames carry 16'h39FF or 16'hC601, MSB first on both channels.
REQ-032 amplitude changes 16'h39FF->16'h5FFF at fcnt=100 -> current frame still 16'h39FF or 16'hC601; next frame 16'h5FFF or 16'hA001.
REQ-033 note_div drops 50000->1000 while tone_cnt=20000 -> phase toggles on the next clk, then every 1000 clk.
REQ-034 amplitude=0, note_div=1000 -> every frame 16'h0000, including the negation of 0.
REQ-035 SPK_MUTE_EN build: mute=1 at fcnt=300 -> next frame all-zero; mute=0 -> tone resumes at the next frame boundary.
